// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory port.
// The arbiter takes the slave view; the core/memory environment takes the master view.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_cancel;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        err;

  modport slave (
    input  i_req, i_addr, i_cancel, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, err
  );

  modport master (
    output i_req, i_addr, i_cancel, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-outstanding memory port,
// with alternating priority, fetch cancel and a sticky memory timeout.
//
// state  | meaning
// IDLE   | no transaction; grant at next edge if a request is pending
// I_BUSY | fetch transaction outstanding on the memory port
// D_BUSY | data transaction outstanding on the memory port
// RESP   | one-cycle ready pulse to the served requester
module mem_arbiter #(
  parameter int TO_W = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  // Timeout fires on the busy cycle that would take the counter to all-ones.
  localparam logic [TO_W-1:0] CNT_TOUT = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          r_state;
  state_t          w_next;
  logic            r_last_d;
  logic            r_cancel;
  logic            r_err;
  logic            r_m_req;
  logic            r_m_we;
  logic [31:0]     r_m_addr;
  logic [31:0]     r_m_wdata;
  logic [31:0]     r_i_rdata;
  logic [31:0]     r_d_rdata;
  logic [TO_W-1:0] r_cnt;

  logic w_busy;
  logic w_ack;
  logic w_tout;
  logic w_gnt_i;
  logic w_gnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = (r_state == I_BUSY) || (r_state == D_BUSY);
    w_ack   = w_busy && bus.m_ack;
    w_tout  = w_busy && !bus.m_ack && (r_cnt == CNT_TOUT);
    // r_last_d doubles as "which requester is in flight" once a grant is made.
    w_gnt_d = (r_state == IDLE) && bus.d_req && (!bus.i_req || !r_last_d);
    w_gnt_i = (r_state == IDLE) && bus.i_req && !w_gnt_d;
    case (r_state)
      IDLE: begin
        if (w_gnt_d)      w_next = D_BUSY;
        else if (w_gnt_i) w_next = I_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (w_ack || w_tout) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d  <= 1'b0;
      r_cancel  <= 1'b0;
      r_err     <= 1'b0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_gnt_i || w_gnt_d) begin
        r_m_req   <= 1'b1;
        r_last_d  <= w_gnt_d;
        r_cnt     <= '0;
        r_m_addr  <= w_gnt_d ? bus.d_addr : bus.i_addr;
        r_m_we    <= w_gnt_d && bus.d_we;
        r_m_wdata <= w_gnt_d ? bus.d_wdata : 32'h0;
      end
      if (w_ack) begin
        r_m_req <= 1'b0;
        if (r_last_d)                      r_d_rdata <= bus.m_rdata;
        else if (!r_cancel && !bus.i_cancel) r_i_rdata <= bus.m_rdata;
      end else if (w_tout) begin
        r_m_req <= 1'b0;
        r_err   <= 1'b1;
        if (r_last_d) r_d_rdata <= 32'h0;
        else          r_i_rdata <= 32'h0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + TO_W'(1);
      end
      if ((r_state == I_BUSY) && bus.i_cancel) r_cancel <= 1'b1;
      else if (r_state == RESP)                r_cancel <= 1'b0;
    end
  end

  // A cancel arriving during RESP itself still suppresses the fetch pulse.
  assign bus.i_ready = (r_state == RESP) && !r_last_d && !r_cancel && !bus.i_cancel;
  assign bus.d_ready = (r_state == RESP) && r_last_d;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;
  assign bus.m_req   = r_m_req;
  assign bus.m_we    = r_m_we;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.err     = r_err;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TO_W, default 8, width of the memory-timeout counter; timeout fires when the counter reaches 2^TO_W-1.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  fetch request, held high until i_ready or i_cancel.
REQ-005 i_addr  input  32  fetch address, stable while i_req is high.
REQ-006 i_cancel  input  1  fetch flush from a branch mispredict; one-cycle pulse.
REQ-007 i_rdata  output  32  fetched word, valid only while i_ready is high.
REQ-008 i_ready  output  1  one-cycle fetch completion pulse.
REQ-009 d_req, d_we  input  1 each  data request and write enable, held until d_ready.
REQ-010 d_addr, d_wdata  input  32 each  data address and store data, stable while d_req is high.
REQ-011 d_rdata  output  32  load word, valid only while d_ready is high.
REQ-012 d_ready  output  1  one-cycle data completion pulse.
REQ-013 m_req, m_we  output  1 each  memory request and write enable, registered.
REQ-014 m_addr, m_wdata  output  32 each  registered memory address and data.
REQ-015 m_rdata  input  32  memory read data, valid with m_ack.
REQ-016 m_ack  input  1  memory completion; m_ack may be high in the first cycle of m_req.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 The arbiter SHALL use the states IDLE, I_BUSY, D_BUSY and RESP, with exactly one memory transaction outstanding.
REQ-019 In IDLE, if only one request is pending, that requester SHALL be granted at the next edge.
- If both are pending, the requester not served by the last grant wins.
- The last-grant register resets to "I", so D wins the first contest.
REQ-020 On a grant, the arbiter SHALL register m_req=1 together with m_addr, m_we (d_we for D, 0 for I) and m_wdata (d_wdata for D, 0 for I).
- It SHALL hold m_req and these values constant until m_ack or timeout.
REQ-021 On a busy-state cycle with m_ack=1, the arbiter SHALL:
- clear m_req at the edge;
- latch m_rdata into the granted requester's rdata register (I only if not cancelled);
- enter RESP.
REQ-022 In RESP, the arbiter SHALL assert exactly one of i_ready/d_ready for one cycle, make no grant, and return to IDLE at the next edge.
REQ-023 Minimum request-to-ready latency SHALL be 2 cycles: req sampled at edge 0, m_ack in cycle 1, ready in cycle 2; the minimum issue period is 3 cycles.
REQ-024 i_cancel in I_BUSY SHALL set a cancel flag: the memory transaction completes normally, i_ready is suppressed in RESP, and the flag clears on entry to IDLE.
REQ-025 i_cancel in IDLE or D_BUSY SHALL have no effect.
REQ-026 i_cancel in RESP for an I transaction SHALL suppress i_ready in that same cycle.
REQ-027 i_rdata/d_rdata SHALL hold their last values outside ready cycles.
- Registered rdata SHALL NOT change for the non-granted port.
REQ-028 A busy-state wait counter SHALL:
- clear on grant and increment every busy cycle without m_ack;
- at 2^TO_W-1, set err, clear m_req, load 32'h0 into the granted rdata, and enter RESP (ready is still pulsed unless cancelled).
REQ-029 m_ack while in IDLE or RESP SHALL be ignored.
REQ-030 err SHALL stay set until reset.

Reset
REQ-031 rst low SHALL immediately force:
- state IDLE, last grant "I", cancel flag 0, counter 0;
- m_req, m_we, i_ready, d_ready, err = 0;
- m_addr, m_wdata, i_rdata, d_rdata = 32'h0.
REQ-032 Reset mid-transaction SHALL drop the transaction without a ready pulse; a late m_ack after reset release SHALL be ignored per REQ-029.

Verification
REQ-033 i_req only, i_addr=0x00400000, m_ack on the first m_req cycle, m_rdata=0x2402000A -> i_ready in cycle 2 with i_rdata=0x2402000A; m_we=0 throughout.
REQ-034 i_req and d_req (store, d_addr=0x10010004, d_wdata=0xCAFEF00D) rise together after reset -> D granted first with m_we=1 and m_wdata=0xCAFEF00D, then I granted with no third grant cycle between them.
REQ-035 Both requests held continuously for 6 grants -> grants alternate D,I,D,I,D,I and each ready pulses exactly once per transaction.
REQ-036 I grant, i_cancel pulsed while m_ack is held low for 3 cycles -> m_req stays high until m_ack, RESP occurs, and i_ready stays 0 throughout.
REQ-037 TO_W=3 with m_ack never asserted on a D load -> after 7 busy cycles err=1, d_ready pulses with d_rdata=0x00000000, and err persists until rst.
REQ-038 rst driven low in D_BUSY, then m_ack asserted after release -> all outputs read 0 asynchronously, no d_ready pulse occurs, and the state is IDLE.
